// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-master read arbiter: slave indices, address
// windows, FSM states and a small one-hot helper.
package axi_read_arbiter_pkg;

    localparam int NUM_SLAVES = 5;

    localparam logic [2:0] S0_IDX      = 3'd0;
    localparam logic [2:0] S1_IDX      = 3'd1;
    localparam logic [2:0] S2_IDX      = 3'd2;
    localparam logic [2:0] S3_IDX      = 3'd3;
    localparam logic [2:0] S4_IDX      = 3'd4;
    localparam logic [2:0] DEFAULT_IDX = 3'd5;

    // S0 starts at address zero, so only its upper bound is needed
    localparam logic [31:0] S0_HI = 32'h0000_1FFF;
    localparam logic [31:0] S1_LO = 32'h0001_0000;
    localparam logic [31:0] S1_HI = 32'h0001_FFFF;
    localparam logic [31:0] S2_LO = 32'h0002_0000;
    localparam logic [31:0] S2_HI = 32'h0002_FFFF;
    localparam logic [31:0] S3_LO = 32'h1000_0000;
    localparam logic [31:0] S3_HI = 32'h1000_03FF;
    localparam logic [31:0] S4_LO = 32'h2000_0000;
    localparam logic [31:0] S4_HI = 32'h201F_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DERR = 2'd3
    } state_t;

    // The default-slave index maps to an all-zero vector
    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [2:0] idx);
        logic [NUM_SLAVES-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == 3'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Maps a 32-bit read address onto a slave index; unmapped addresses go to
// the default (error) slave.
module axi_addr_decoder
    import axi_read_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  idx
);

    always_comb begin
        idx = DEFAULT_IDX;
        if (addr <= S0_HI) begin
            idx = S0_IDX;
        end else if (addr >= S1_LO && addr <= S1_HI) begin
            idx = S1_IDX;
        end else if (addr >= S2_LO && addr <= S2_HI) begin
            idx = S2_IDX;
        end else if (addr >= S3_LO && addr <= S3_HI) begin
            idx = S3_IDX;
        end else if (addr >= S4_LO && addr <= S4_HI) begin
            idx = S4_IDX;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master, five-slave AXI read-channel arbiter with round-robin grant,
// single outstanding transaction and a built-in decode-error slave.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ARVALID_M0,
    input  logic                  ARVALID_M1,
    input  logic [31:0]           ARADDR_M0,
    input  logic [31:0]           ARADDR_M1,
    input  logic [3:0]            ARLEN_M0,
    input  logic [3:0]            ARLEN_M1,
    output logic                  ARREADY_M0,
    output logic                  ARREADY_M1,
    input  logic                  RREADY_M0,
    input  logic                  RREADY_M1,
    output logic                  RVALID_M0,
    output logic                  RVALID_M1,
    output logic [NUM_SLAVES-1:0] ARVALID_S,
    input  logic [NUM_SLAVES-1:0] ARREADY_S,
    input  logic [NUM_SLAVES-1:0] RVALID_S,
    input  logic [NUM_SLAVES-1:0] RLAST_S,
    output logic [NUM_SLAVES-1:0] RREADY_S,
    output logic                  m_sel,
    output logic [2:0]            s_sel,
    output logic                  dec_err,
    output logic                  derr_last
);

    state_t      state_reg, state_next;
    logic        ptr_reg, ptr_next;
    logic        m_sel_reg, m_sel_next;
    logic [2:0]  s_sel_reg, s_sel_next;
    logic [3:0]  len_reg, len_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic [31:0] addr_m [2];
    logic [3:0]  len_m  [2];
    logic [2:0]  dec_idx [2];
    logic [1:0]  arvalid_m, rready_m, arready_m, rvalid_m;
    logic        grant;
    logic [NUM_SLAVES-1:0] s_onehot;

    assign addr_m[0]  = ARADDR_M0;
    assign addr_m[1]  = ARADDR_M1;
    assign len_m[0]   = ARLEN_M0;
    assign len_m[1]   = ARLEN_M1;
    assign arvalid_m  = {ARVALID_M1, ARVALID_M0};
    assign rready_m   = {RREADY_M1, RREADY_M0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            axi_addr_decoder u_dec (
                .addr (addr_m[gi]),
                .idx  (dec_idx[gi])
            );
        end
    endgenerate

    // Pointer only matters when both masters ask; a lone requester always wins
    assign grant    = (arvalid_m == 2'b11) ? ptr_reg : arvalid_m[1];
    assign s_onehot = slave_onehot(s_sel_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            m_sel_reg <= 1'b0;
            s_sel_reg <= 3'd0;
            len_reg   <= 4'd0;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            m_sel_reg <= m_sel_next;
            s_sel_reg <= s_sel_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        m_sel_next = m_sel_reg;
        s_sel_next = s_sel_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        arready_m  = 2'b00;
        rvalid_m   = 2'b00;
        ARVALID_S  = '0;
        RREADY_S   = '0;
        dec_err    = 1'b0;
        derr_last  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|arvalid_m) begin
                    m_sel_next = grant;
                    s_sel_next = dec_idx[grant];
                    len_next   = len_m[grant];
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (s_sel_reg == DEFAULT_IDX) begin
                    arready_m[m_sel_reg] = 1'b1;
                    cnt_next             = 4'd0;
                    state_next           = DERR;
                end else begin
                    ARVALID_S            = s_onehot;
                    arready_m[m_sel_reg] = |(ARREADY_S & s_onehot);
                    if (|(ARREADY_S & s_onehot)) begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                rvalid_m[m_sel_reg] = |(RVALID_S & s_onehot);
                RREADY_S            = rready_m[m_sel_reg] ? s_onehot : '0;
                if (rready_m[m_sel_reg] && |(RVALID_S & RLAST_S & s_onehot)) begin
                    ptr_next   = ~m_sel_reg;
                    state_next = IDLE;
                end
            end
            DERR: begin
                rvalid_m[m_sel_reg] = 1'b1;
                dec_err             = 1'b1;
                derr_last           = (cnt_reg == len_reg);
                // Exiting on the last beat keeps a 4-bit counter from wrapping at ARLEN=15
                if (rready_m[m_sel_reg]) begin
                    if (cnt_reg == len_reg) begin
                        ptr_next   = ~m_sel_reg;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ARREADY_M0 = arready_m[0];
    assign ARREADY_M1 = arready_m[1];
    assign RVALID_M0  = rvalid_m[0];
    assign RVALID_M1  = rvalid_m[1];
    assign m_sel      = m_sel_reg;
    assign s_sel      = s_sel_reg;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: per-beat expectations are queued when a
// request is issued and popped as each R handshake appears.
module tb_axi_read_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ARVALID_M0 = 0, ARVALID_M1 = 0;
    logic [31:0] ARADDR_M0 = 0, ARADDR_M1 = 0;
    logic [3:0]  ARLEN_M0 = 0, ARLEN_M1 = 0;
    logic        ARREADY_M0, ARREADY_M1;
    logic        RREADY_M0 = 0, RREADY_M1 = 0;
    logic        RVALID_M0, RVALID_M1;
    logic [4:0]  ARVALID_S;
    logic [4:0]  ARREADY_S = 0;
    logic [4:0]  RVALID_S = 0;
    logic [4:0]  RLAST_S = 0;
    logic [4:0]  RREADY_S;
    logic        m_sel;
    logic [2:0]  s_sel;
    logic        dec_err, derr_last;

    int checks = 0;
    int errors = 0;
    bit model_ptr = 1'b0;
    bit ab;

    typedef struct {
        bit         m;
        logic [2:0] s;
        bit         derr;
        bit         last;
    } beat_t;
    beat_t sb[$];

    axi_read_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .ARVALID_M0 (ARVALID_M0),
        .ARVALID_M1 (ARVALID_M1),
        .ARADDR_M0  (ARADDR_M0),
        .ARADDR_M1  (ARADDR_M1),
        .ARLEN_M0   (ARLEN_M0),
        .ARLEN_M1   (ARLEN_M1),
        .ARREADY_M0 (ARREADY_M0),
        .ARREADY_M1 (ARREADY_M1),
        .RREADY_M0  (RREADY_M0),
        .RREADY_M1  (RREADY_M1),
        .RVALID_M0  (RVALID_M0),
        .RVALID_M1  (RVALID_M1),
        .ARVALID_S  (ARVALID_S),
        .ARREADY_S  (ARREADY_S),
        .RVALID_S   (RVALID_S),
        .RLAST_S    (RLAST_S),
        .RREADY_S   (RREADY_S),
        .m_sel      (m_sel),
        .s_sel      (s_sel),
        .dec_err    (dec_err),
        .derr_last  (derr_last)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_decode(input logic [31:0] a);
        if (a <= 32'h0000_1FFF) return 3'd0;
        if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 3'd1;
        if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 3'd2;
        if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3'd3;
        if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic [4:0] ref_onehot(input logic [2:0] s);
        logic [4:0] one;
        one = 5'b00001;
        return (s < 3'd5) ? (one << s) : 5'b00000;
    endfunction

    function automatic logic get_arready(input bit m);
        return m ? ARREADY_M1 : ARREADY_M0;
    endfunction

    function automatic logic get_rvalid(input bit m);
        return m ? RVALID_M1 : RVALID_M0;
    endfunction

    task automatic set_master(input bit m, input logic v, input logic [31:0] a, input logic [3:0] l);
        if (m) begin
            ARVALID_M1 = v; ARADDR_M1 = a; ARLEN_M1 = l;
        end else begin
            ARVALID_M0 = v; ARADDR_M0 = a; ARLEN_M0 = l;
        end
    endtask

    task automatic set_rready(input bit m, input logic r);
        if (m) RREADY_M1 = r;
        else   RREADY_M0 = r;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rvalid_m0"}, 32'(RVALID_M0), 32'd0);
        check({tag, "_rvalid_m1"}, 32'(RVALID_M1), 32'd0);
        check({tag, "_arready_m"}, 32'({ARREADY_M1, ARREADY_M0}), 32'd0);
        check({tag, "_arvalid_s"}, 32'(ARVALID_S), 32'd0);
        check({tag, "_rready_s"}, 32'(RREADY_S), 32'd0);
        check({tag, "_dec_err"}, 32'(dec_err), 32'd0);
        check({tag, "_derr_last"}, 32'(derr_last), 32'd0);
    endtask

    // Called just after a falling edge with the arbiter idle
    task automatic run_txn(input bit req0, input bit req1, input logic [31:0] addr,
                           input logic [3:0] len, input int ar_delay, input bit toggle,
                           input int abort_beat, output bit aborted);
        bit         win;
        bit         rr;
        bit         done;
        bit         exp_rdy;
        logic [2:0] s;
        logic [4:0] oh;
        int         beat;
        beat_t      e;

        win     = (req0 && req1) ? model_ptr : req1;
        s       = ref_decode(addr);
        oh      = ref_onehot(s);
        beat    = 0;
        done    = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            sb.push_back('{win, s, (s == 3'd5), (i == int'(len))});
        end

        set_master(win, 1'b1, addr, len);
        if (req0 && req1) set_master(~win, 1'b1, 32'h0002_0010, 4'd1);
        @(negedge clock);
        check("grant_m_sel", 32'(m_sel), 32'(win));
        check("grant_s_sel", 32'(s_sel), 32'(s));
        set_master(~win, 1'b0, 32'd0, 4'd0);

        for (int k = 0; k < 40; k++) begin
            ARREADY_S = (k >= ar_delay) ? oh : 5'b0;
            #1;
            exp_rdy = (s == 3'd5) || (k >= ar_delay);
            check("addr_arvalid_s", 32'(ARVALID_S), 32'(oh));
            check("addr_arready_other", 32'(get_arready(~win)), 32'd0);
            check("addr_arready_m", 32'(get_arready(win)), 32'(exp_rdy));
            if (exp_rdy) break;
            @(negedge clock);
        end

        @(negedge clock);
        set_master(win, 1'b0, 32'd0, 4'd0);
        ARREADY_S = 5'b0;
        #1;
        check("post_addr_arready", 32'(get_arready(win)), 32'd0);

        for (int c = 0; c < 100 && !done; c++) begin
            rr = toggle ? ((c % 2) == 0) : 1'b1;
            set_rready(win, rr);
            RVALID_S = oh;
            RLAST_S  = (beat == int'(len)) ? oh : 5'b0;
            #1;
            check("data_rvalid_other", 32'(get_rvalid(~win)), 32'd0);
            check("data_rvalid_m", 32'(get_rvalid(win)), 32'd1);
            if (abort_beat != 0 && beat == abort_beat - 1) begin
                reset = 1'b1;
                #1;
                check_all_zero("abort");
                check("abort_m_sel", 32'(m_sel), 32'd0);
                check("abort_s_sel", 32'(s_sel), 32'd0);
                aborted = 1'b1;
                done    = 1'b1;
            end else if (get_rvalid(win) && rr) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("beat_m_sel", 32'(m_sel), 32'(e.m));
                    check("beat_s_sel", 32'(s_sel), 32'(e.s));
                    check("beat_dec_err", 32'(dec_err), 32'(e.derr));
                    check("beat_derr_last", 32'(derr_last), 32'(e.derr && e.last));
                    check("beat_rready_s", 32'(RREADY_S), 32'(e.derr ? 5'b0 : oh));
                end
                beat++;
                if (beat == int'(len) + 1) done = 1'b1;
            end else begin
                check("stall_rready_s", 32'(RREADY_S), 32'd0);
            end
            if (!aborted) @(negedge clock);
        end
        if (!done) check("txn_timeout_beats", 32'(beat), 32'(int'(len) + 1));

        if (!aborted) begin
            RVALID_S = 5'b0;
            RLAST_S  = 5'b0;
            set_rready(win, 1'b1);
            #1;
            check_all_zero("idle_after");
            set_rready(win, 1'b0);
            check("sb_empty", 32'(sb.size()), 32'd0);
            model_ptr = ~win;
        end
        $display("txn req=%b%b addr=%08h len=%0d winner=M%0d slave=%0d beats=%0d aborted=%0d",
                 req1, req0, addr, len, win, s, beat, aborted);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clock);
        check_all_zero("reset_clocked");
        check("reset_m_sel", 32'(m_sel), 32'd0);
        check("reset_s_sel", 32'(s_sel), 32'd0);
        reset = 1'b0;
        #1;

        // Contention out of reset: M0, then M1, then M0 again
        run_txn(1, 1, 32'h0000_0100, 4'd1, 0, 0, 0, ab);
        run_txn(1, 1, 32'h0001_0200, 4'd0, 0, 0, 0, ab);
        run_txn(1, 1, 32'h0000_0300, 4'd0, 1, 0, 0, ab);

        // Single read to S1; pointer now favours M1 but M0 is alone
        run_txn(1, 0, 32'h0001_0004, 4'd0, 0, 0, 0, ab);

        // Decode miss, 4 beats, ready toggling
        run_txn(0, 1, 32'h3000_0000, 4'd3, 0, 1, 0, ab);

        // Address backpressure and data toggling on S4
        run_txn(1, 0, 32'h2000_0100, 4'd7, 5, 1, 0, ab);

        // Address map boundaries
        run_txn(1, 0, 32'h0000_1FFF, 4'd0, 0, 0, 0, ab);
        run_txn(0, 1, 32'h0000_2000, 4'd0, 0, 0, 0, ab);
        run_txn(1, 0, 32'h201F_FFFF, 4'd2, 2, 0, 0, ab);
        run_txn(0, 1, 32'h2020_0000, 4'd0, 0, 0, 0, ab);
        run_txn(1, 0, 32'h1000_03FF, 4'd0, 0, 0, 0, ab);
        run_txn(0, 1, 32'h0002_FFFF, 4'd1, 0, 0, 0, ab);

        // Longest error burst, counter must not wrap
        run_txn(1, 0, 32'hFFFF_FFFF, 4'd15, 0, 0, 0, ab);

        // Reset during beat 2 of a 4-beat read, pointer left at M1 beforehand
        run_txn(1, 0, 32'h2000_0000, 4'd3, 0, 0, 2, ab);
        check("abort_taken", 32'(ab), 32'd1);
        RVALID_S = 5'b0; RLAST_S = 5'b0; ARREADY_S = 5'b0;
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
        set_master(1'b0, 1'b0, 32'd0, 4'd0);
        set_master(1'b1, 1'b0, 32'd0, 4'd0);
        @(negedge clock);
        check_all_zero("held_reset");
        sb.delete();
        model_ptr = 1'b0;
        reset = 1'b0;
        #1;
        run_txn(1, 1, 32'h0000_0040, 4'd0, 0, 0, 0, ab);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be listed as `name  direction  width  meaning`, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
REQ-002 The block SHALL have these master-side ports:
- ARVALID_M0 / ARVALID_M1  in  1  read-address request
- ARADDR_M0 / ARADDR_M1  in  32  request address
- ARLEN_M0 / ARLEN_M1  in  4  burst length minus 1
- ARREADY_M0 / ARREADY_M1  out  1  address accepted
- RREADY_M0 / RREADY_M1  in  1  master ready for data
- RVALID_M0 / RVALID_M1  out  1  routed read-data valid
REQ-003 The block SHALL have these slave-side ports:
- ARVALID_S  out  5  one-hot, bit n drives slave Sn
- ARREADY_S  in  5  per-slave address ready
- RVALID_S  in  5  per-slave data valid
- RLAST_S  in  5  per-slave last beat
- RREADY_S  out  5  one-hot per-slave data ready
REQ-004 The block SHALL have these datapath-control ports:
- m_sel  out  1  granted master
- s_sel  out  3  selected slave; 0-4 = S0-S4, 5 = default slave
- dec_err  out  1  default slave active; datapath forces RRESP=2'b11, RDATA=0
- derr_last  out  1  RLAST for a default-slave beat

Function
REQ-005 The address map SHALL be: S0 0x0000_0000-0x0000_1FFF; S1 0x0001_0000-0x0001_FFFF; S2 0x0002_0000-0x0002_FFFF; S3 0x1000_0000-0x1000_03FF; S4 0x2000_0000-0x201F_FFFF; all other addresses decode to default slave (5).
REQ-006 The FSM SHALL have the states IDLE, ADDR, DATA and DERR.
REQ-007 In IDLE, if any ARVALID_Mx is high, the block SHALL grant one master, register m_sel, the decoded s_sel and ARLEN, and enter ADDR on the next edge.
REQ-008 Arbitration SHALL be round-robin: when both ARVALID_M0 and ARVALID_M1 are high, the master holding the priority pointer wins; the pointer SHALL move to the other master when a transaction completes (last R handshake).
REQ-009 If only one ARVALID_Mx is high, that master SHALL be granted regardless of the pointer, and the pointer SHALL still update on completion.
REQ-010 In ADDR with s_sel<5, ARVALID_S[s_sel] SHALL be 1 and ARREADY_M[m_sel] SHALL equal ARREADY_S[s_sel] combinationally; on that handshake the FSM SHALL enter DATA.
REQ-011 In ADDR with s_sel=5, ARREADY_M[m_sel] SHALL be 1 for exactly one cycle, ARVALID_S SHALL stay 0, and the FSM SHALL enter DERR.
REQ-012 In DATA, RVALID_M[m_sel] SHALL equal RVALID_S[s_sel] and RREADY_S[s_sel] SHALL equal RREADY_M[m_sel]; all other RVALID and RREADY outputs SHALL be 0.
REQ-013 DATA SHALL exit to IDLE only on RVALID_S & RREADY_M & RLAST_S, all at index s_sel.
REQ-014 In DERR, RVALID_M[m_sel] and dec_err SHALL be 1.
REQ-015 A beat counter SHALL count ARLEN+1 beats in DERR.
REQ-016 derr_last SHALL be 1 when the counter equals the latched ARLEN.
REQ-017 The DERR counter SHALL advance only on RREADY_M[m_sel]; DERR SHALL exit to IDLE on the last handshake.
REQ-018 The beat counter SHALL be 4 bits, clear on entry to DERR, and SHALL NOT wrap (ARLEN=15 gives 16 beats).
REQ-019 Only one transaction SHALL be outstanding; ARREADY_M0 and ARREADY_M1 SHALL be 0 outside ADDR.
REQ-020 The block SHALL accept a new request in the IDLE cycle immediately following the exit from DATA or DERR.
REQ-021 A master dropping ARVALID after being granted SHALL NOT be checked; the latched request SHALL be completed.

Reset
REQ-022 On reset the FSM SHALL go to IDLE, the priority pointer to M0, and m_sel, s_sel, counter and latched ARLEN to 0.
REQ-023 During reset all ARVALID_S, RREADY_S, ARREADY_Mx, RVALID_Mx, dec_err and derr_last outputs SHALL be 0.
REQ-024 Reset asserted mid-burst SHALL abandon the transaction without any further handshake.

Structure
REQ-025 The slave index constants (S0-S4, DEFAULT=5), the address-range bounds and the state enum SHALL live in the shared AXI package.
REQ-026 The address decoder SHALL be one sub-module, axi_addr_decoder (32-bit address in, 3-bit index out), instantiated once per master.

Verification
REQ-027 Single read: M0 reads 0x0001_0004 with ARLEN=0 and S1 ARREADY=1 -> ARVALID_S=5'b00010 one cycle after ARVALID_M0; one R beat routed; return to IDLE.
REQ-028 Contention: M0 and M1 request in the same cycle out of reset -> M0 served first, then M1, then M0 again if it re-requests.
REQ-029 Decode miss: M1 reads 0x3000_0000 with ARLEN=3 -> no ARVALID_S; 4 beats with dec_err=1; derr_last only on the 4th beat.
REQ-030 Backpressure: S4 holds ARREADY low 5 cycles and RREADY_M0 toggles each cycle during an 8-beat burst -> ARVALID_S[4] held stable; exactly 8 beats transferred; exit only on RLAST.
REQ-031 Reset mid-op: reset asserted during beat 2 of a 4-beat DRAM read -> all outputs 0 immediately; after release M0 has priority.
REQ-032 Boundaries: addresses 0x0000_1FFF, 0x0000_2000, 0x201F_FFFF and 0x2020_0000 -> S0, default, S4 and default respectively.
